// File: rtl/pll_rst_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_rst_pkg;

  // Sequencer states, in bring-up order.
  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Defaults for a 24 MHz reference clock.
  localparam int DEF_RST_HOLD_CYC     = 16;
  localparam int DEF_LOCK_TIMEOUT_CYC = 24000;
  localparam int DEF_LOCK_STABLE_CYC  = 256;
  localparam int DEF_RETRY_MAX        = 7;

  // Larger of two integers; used to size the shared cycle counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample on the same edge,
      // so r_sync receives the old r_meta and the chain is a true two-stage delay.
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_rst_ctrl.sv
// PLL reset sequencer and system reset generator, clocked by the PLL refclk.
// Holds the PLL in reset, waits for a synchronized lock, requires the lock to
// stay high for LOCK_STABLE_CYC cycles, then releases sys_rst_n. Lock loss in
// RUN restarts the sequence and sets the sticky lock_lost flag.
// Optional feature macro PLL_RST_CTRL_TIMEOUT_EN: when defined, WAIT_LOCK times
// out after LOCK_TIMEOUT_CYC cycles and retries up to RETRY_MAX times before
// parking in FAIL; when undefined, WAIT_LOCK waits forever and retry_cnt and
// lock_fail stay 0.
// RETRY_MAX must be at least 1.
module pll_rst_ctrl
  import pll_rst_pkg::*;
#(
  parameter int RST_HOLD_CYC     = DEF_RST_HOLD_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int RETRY_MAX        = DEF_RETRY_MAX
) (
  input  logic                             refclk,
  input  logic                             reset_n,
  input  logic                             extlock,
  input  logic                             clr_status,
  output logic                             pll_reset,
  output logic                             sys_rst_n,
  output logic                             pll_ready,
  output logic [$clog2(RETRY_MAX+1)-1:0]   retry_cnt,
  output logic                             lock_lost,
  output logic                             lock_fail
);

  localparam int RETRY_W = $clog2(RETRY_MAX + 1);

`ifdef PLL_RST_CTRL_TIMEOUT_EN
  localparam int CNT_MAX = max_int(max_int(RST_HOLD_CYC, LOCK_STABLE_CYC), LOCK_TIMEOUT_CYC);
`else
  localparam int CNT_MAX = max_int(RST_HOLD_CYC, LOCK_STABLE_CYC);
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry_cnt;
  logic               r_pll_reset;
  logic               r_sys_rst_n;
  logic               r_pll_ready;
  logic               r_lock_lost;
  logic               r_lock_fail;

  logic w_lock_s;
  logic w_hold_done;
  logic w_stable_done;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (reset_n),
    .i_d   (extlock),
    .o_q   (w_lock_s)
  );

  // The shared counter holds cycles elapsed in the current state; it is
  // cleared on every state change, so "done" fires on the Nth cycle in state.
  assign w_hold_done   = (r_cnt == CNT_W'(RST_HOLD_CYC - 1));
  assign w_stable_done = (r_cnt == CNT_W'(LOCK_STABLE_CYC - 1));

`ifdef PLL_RST_CTRL_TIMEOUT_EN
  logic w_timeout;
  assign w_timeout = (r_cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1));
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (LOCK_TIMEOUT_CYC > 0);
`endif

  // Sequencer FSM with shared counter, retry counter and sticky flags.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= HOLD;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      r_pll_reset <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_pll_ready <= 1'b0;
      r_lock_lost <= 1'b0;
      r_lock_fail <= 1'b0;
    end else begin
      // Count cycles in state, saturating rather than wrapping.
      if (r_cnt != CNT_W'(CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end

      // Clearing here and setting later in the case lets a same-cycle lock
      // loss override the clear, so the loss is never silently dropped.
      if (clr_status) begin
        r_lock_lost <= 1'b0;
      end

      case (r_state)
        HOLD: begin
          if (w_hold_done) begin
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_pll_reset <= 1'b0;
          end
        end

        WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= STABLE;
            r_cnt   <= '0;
          end
`ifdef PLL_RST_CTRL_TIMEOUT_EN
          else if (w_timeout) begin
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            if (r_retry_cnt == RETRY_W'(RETRY_MAX)) begin
              r_state     <= FAIL;
              r_lock_fail <= 1'b1;
            end else begin
              r_state     <= HOLD;
              r_retry_cnt <= r_retry_cnt + 1'b1;
            end
          end
`endif
        end

        STABLE: begin
          if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (w_stable_done) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_sys_rst_n <= 1'b1;
            r_pll_ready <= 1'b1;
            r_retry_cnt <= '0;
          end
        end

        RUN: begin
          if (!w_lock_s) begin
            r_state     <= HOLD;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_sys_rst_n <= 1'b0;
            r_pll_ready <= 1'b0;
            r_lock_lost <= 1'b1;
          end
        end

        FAIL: begin
          if (clr_status) begin
            r_state     <= HOLD;
            r_cnt       <= '0;
            r_retry_cnt <= '0;
            r_lock_fail <= 1'b0;
          end
        end

        default: begin
          r_state     <= HOLD;
          r_cnt       <= '0;
          r_pll_reset <= 1'b1;
          r_sys_rst_n <= 1'b0;
          r_pll_ready <= 1'b0;
          r_lock_fail <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset = r_pll_reset;
  assign sys_rst_n = r_sys_rst_n;
  assign pll_ready = r_pll_ready;
  assign retry_cnt = r_retry_cnt;
  assign lock_lost = r_lock_lost;
  assign lock_fail = r_lock_fail;

endmodule

// File: tb/tb_pll_rst_ctrl.sv
// Self-checking bench for pll_rst_ctrl. Expected output vectors are queued with
// the edge at which they must hold and compared half a cycle after that edge.
// Timeout/retry scenarios follow PLL_RST_CTRL_TIMEOUT_EN; the wait-forever
// scenario runs when it is undefined.
module tb_pll_rst_ctrl;

  localparam int HOLD_C  = 4;
  localparam int TO_C    = 50;
  localparam int STAB_C  = 8;
  localparam int RMAX    = 2;

  logic       refclk     = 1'b0;
  logic       reset_n    = 1'b0;
  logic       extlock    = 1'b0;
  logic       clr_status = 1'b0;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       pll_ready;
  logic [1:0] retry_cnt;
  logic       lock_lost;
  logic       lock_fail;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;

  typedef struct packed {
    int         at_edge;
    logic [6:0] val;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];

  logic [6:0] obs;
  assign obs = {pll_reset, sys_rst_n, pll_ready, lock_lost, lock_fail, retry_cnt};

  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  pll_rst_ctrl #(
    .RST_HOLD_CYC     (HOLD_C),
    .LOCK_TIMEOUT_CYC (TO_C),
    .LOCK_STABLE_CYC  (STAB_C),
    .RETRY_MAX        (RMAX)
  ) dut (
    .refclk     (refclk),
    .reset_n    (reset_n),
    .extlock    (extlock),
    .clr_status (clr_status),
    .pll_reset  (pll_reset),
    .sys_rst_n  (sys_rst_n),
    .pll_ready  (pll_ready),
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost),
    .lock_fail  (lock_fail)
  );

  // Pack {pll_reset, sys_rst_n, pll_ready, lock_lost, lock_fail, retry_cnt}.
  function automatic logic [6:0] mk(input bit pr, input bit sr, input bit rdy,
                                    input bit ll, input bit lf, input logic [1:0] rc);
    return {pr, sr, rdy, ll, lf, rc};
  endfunction

  task automatic expect_at(input int rel, input string tag, input logic [6:0] v);
    exp_t e;
    e.at_edge = base + rel;
    e.val     = v;
    sb.push_back(e);
    sb_tag.push_back(tag);
  endtask

  // Return 1 time unit after edge base+rel.
  task automatic wait_edge(input int rel);
    while (cyc < base + rel) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check_now(input string tag, input logic [6:0] v);
    tests++;
    assert (obs === v) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, v);
    end
  endtask

  task automatic monitor();
    exp_t  e;
    string t;
    forever begin
      @(negedge refclk);
      while (sb.size() > 0 && sb[0].at_edge <= cyc) begin
        e = sb.pop_front();
        t = sb_tag.pop_front();
        tests++;
        assert (e.at_edge == cyc && obs === e.val) else begin
          fails++;
          $error("FAIL %s: at edge %0d got %b expected %b for edge %0d",
                 t, cyc - base, obs, e.val, e.at_edge - base);
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 1000) begin
      @(negedge refclk);
      #1;
      n++;
    end
    while (sb.size() > 0) begin
      tests++;
      fails++;
      $error("FAIL %s: expectation never reached, expected %b", sb_tag[0], sb[0].val);
      sb.delete(0);
      sb_tag.delete(0);
    end
  endtask

  // Assert reset, check reset values, then release just after edge 0.
  task automatic do_reset(input logic lock);
    reset_n    = 1'b0;
    extlock    = lock;
    clr_status = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    check_now("reset_values", mk(1, 0, 0, 0, 0, 2'd0));
    @(posedge refclk);
    #1;
    base    = cyc;
    reset_n = 1'b1;
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Normal bring-up: lock at edge 10, release at 10+3+8.
    do_reset(1'b0);
    expect_at(0,  "t1_rel0",         mk(1, 0, 0, 0, 0, 2'd0));
    expect_at(3,  "t1_hold",         mk(1, 0, 0, 0, 0, 2'd0));
    expect_at(4,  "t1_pll_rst_fall", mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(20, "t1_pre_release",  mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(21, "t1_release",      mk(0, 1, 1, 0, 0, 2'd0));
    wait_edge(10); extlock = 1'b1;
    wait_edge(22);
    drain();

    // Lock glitch in STABLE, then lock loss in RUN and sticky flag handling.
    do_reset(1'b0);
    expect_at(21, "t2_no_early_release", mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(28, "t2_pre_release",      mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(29, "t2_release",          mk(0, 1, 1, 0, 0, 2'd0));
    expect_at(37, "t3_still_run",        mk(0, 1, 1, 0, 0, 2'd0));
    expect_at(38, "t3_lock_lost",        mk(1, 0, 0, 1, 0, 2'd0));
    expect_at(42, "t3_hold_done",        mk(0, 0, 0, 1, 0, 2'd0));
    expect_at(44, "t3_lost_sticky",      mk(0, 0, 0, 1, 0, 2'd0));
    expect_at(45, "t3_clr_lost",         mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(61, "t3_rerun",            mk(0, 1, 1, 0, 0, 2'd0));
    expect_at(69, "t3_set_wins",         mk(1, 0, 0, 1, 0, 2'd0));
    expect_at(71, "t3_clr_in_hold",      mk(1, 0, 0, 0, 0, 2'd0));
    wait_edge(10); extlock    = 1'b1;
    wait_edge(16); extlock    = 1'b0;
    wait_edge(18); extlock    = 1'b1;
    wait_edge(35); extlock    = 1'b0;
    wait_edge(44); clr_status = 1'b1;
    wait_edge(45); clr_status = 1'b0;
    wait_edge(50); extlock    = 1'b1;
    wait_edge(66); extlock    = 1'b0;
    wait_edge(68); clr_status = 1'b1;
    wait_edge(69); clr_status = 1'b0;
    wait_edge(70); clr_status = 1'b1;
    wait_edge(71); clr_status = 1'b0;
    wait_edge(72);
    drain();

`ifdef PLL_RST_CTRL_TIMEOUT_EN
    // Timeouts: retry 1, retry 2, then FAIL; clr_status restarts the sequence.
    do_reset(1'b0);
    expect_at(53,  "t4_wait",       mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(54,  "t4_retry1",     mk(1, 0, 0, 0, 0, 2'd1));
    expect_at(58,  "t4_rewait",     mk(0, 0, 0, 0, 0, 2'd1));
    expect_at(108, "t4_retry2",     mk(1, 0, 0, 0, 0, 2'd2));
    expect_at(161, "t4_pre_fail",   mk(0, 0, 0, 0, 0, 2'd2));
    expect_at(162, "t4_fail",       mk(1, 0, 0, 0, 1, 2'd2));
    expect_at(200, "t4_fail_held",  mk(1, 0, 0, 0, 1, 2'd2));
    expect_at(206, "t4_clr_fail",   mk(1, 0, 0, 0, 0, 2'd0));
    expect_at(210, "t4_hold_done",  mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(219, "t4_run",        mk(0, 1, 1, 0, 0, 2'd0));
    wait_edge(180); extlock    = 1'b1;
    wait_edge(205); clr_status = 1'b1;
    wait_edge(206); clr_status = 1'b0;
    wait_edge(220);
    drain();

    // One timeout, then lock: retry_cnt clears on RUN entry.
    do_reset(1'b0);
    expect_at(54, "t4b_retry1",        mk(1, 0, 0, 0, 0, 2'd1));
    expect_at(70, "t4b_pre_run",       mk(0, 0, 0, 0, 0, 2'd1));
    expect_at(71, "t4b_run_clr_retry", mk(0, 1, 1, 0, 0, 2'd0));
    wait_edge(60); extlock = 1'b1;
    wait_edge(72);
    drain();
`else
    // No timeout: WAIT_LOCK holds for 500 cycles and still accepts a late lock.
    do_reset(1'b0);
    expect_at(4,   "t6_wait",       mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(54,  "t6_no_timeout", mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(250, "t6_mid_wait",   mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(504, "t6_still_wait", mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(514, "t6_pre_run",    mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(515, "t6_run",        mk(0, 1, 1, 0, 0, 2'd0));
    wait_edge(504); extlock = 1'b1;
    wait_edge(516);
    drain();
`endif

    // Asynchronous reset mid-STABLE: outputs return to reset values at once.
    do_reset(1'b0);
    expect_at(8, "t5_stable", mk(0, 0, 0, 0, 0, 2'd0));
    wait_edge(5); extlock = 1'b1;
    wait_edge(11);
    drain();
    #2 reset_n = 1'b0;
    #1 check_now("t5_async_mid_stable", mk(1, 0, 0, 0, 0, 2'd0));

    // Asynchronous reset in RUN: sys_rst_n and pll_ready drop without an edge.
    do_reset(1'b1);
    expect_at(12, "t5_pre_run", mk(0, 0, 0, 0, 0, 2'd0));
    expect_at(13, "t5_run",     mk(0, 1, 1, 0, 0, 2'd0));
    wait_edge(15);
    drain();
    #2 reset_n = 1'b0;
    #1 check_now("t5_async_in_run", mk(1, 0, 0, 0, 0, 2'd0));

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
